// File: rtl/up5bit_pkg.sv
// Shared types and default constants for the 5-bit up-counter checker.
package up5bit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK
  } checker_state_t;

  localparam int unsigned DEF_WIDTH       = 5;
  localparam int unsigned DEF_LOCK_CNT    = 2;
  localparam int unsigned DEF_LOSS_THRESH = 3;
  localparam int unsigned DEF_STAT_W      = 8;

  // Largest value a count bus of the given width can carry; the wrap point.
  function automatic int unsigned max_count(input int unsigned width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/up5bit_count_checker_sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
  parameter int unsigned STAT_W = 8
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  // Count one per enabled cycle, holding once every bit is set.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/up5bit_count_checker.sv
// Sits behind one counter output, locks onto the +1 sequence and reports
// breaks and wraps on pins, with saturating totals for both.
module up5bit_count_checker
  import up5bit_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
  parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int unsigned STAT_W      = DEF_STAT_W
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_bad
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

  localparam logic [WIDTH-1:0]  MAX_VAL   = WIDTH'(max_count(WIDTH));
  localparam logic [RUN_W-1:0]  LOCK_V    = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] LOSS_V    = MISS_W'(LOSS_THRESH);

  checker_state_t     state;
  logic [WIDTH-1:0]   expected;
  logic [RUN_W-1:0]   run;
  logic [MISS_W-1:0]  miss;

  logic               match;
  logic               err_inc;
  logic               wrap_inc;
  logic [RUN_W-1:0]   run_inc;
  logic [MISS_W-1:0]  miss_inc;

  // Successor of a count value, folding the maximum back to zero.
  function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
    return (v == MAX_VAL) ? '0 : v + 1'b1;
  endfunction

  // Compare the sample against the prediction and flag the tracked events.
  always_comb begin
    match    = (count_in == expected);
    run_inc  = run + 1'b1;
    miss_inc = miss + 1'b1;
    err_inc  = en && (state == TRACK) && !match;
    wrap_inc = en && (state == TRACK) && match && (count_in == '0);
  end

  // Lock FSM with the prediction register, run/miss counters and pulses.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      expected   <= '0;
      run        <= '0;
      miss       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      last_bad   <= '0;
    end else begin
      err_pulse  <= err_inc;
      wrap_pulse <= wrap_inc;
      if (en) begin
        case (state)
          IDLE: begin
            expected <= next_val(count_in);
            run      <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            expected <= next_val(count_in);
            if (match) begin
              run <= run_inc;
              if (run_inc == LOCK_V) begin
                state  <= TRACK;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              run <= '0;
            end
          end
          TRACK: begin
            if (match) begin
              expected <= next_val(expected);
              miss     <= '0;
            end else begin
              last_bad <= count_in;
              miss     <= miss_inc;
              if (miss_inc == LOSS_V) begin
                state    <= ACQUIRE;
                locked   <= 1'b0;
                run      <= '0;
                expected <= next_val(count_in);
              end else begin
                expected <= next_val(expected);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(.STAT_W(STAT_W)) u_err_count (
    .clk0  (clk0),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.STAT_W(STAT_W)) u_wrap_count (
    .clk0  (clk0),
    .reset (reset),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_up5bit_count_checker.sv
// Bench for up5bit_count_checker: directed scenarios plus a random stream,
// all outputs compared each cycle against a behavioural model.
module tb_up5bit_count_checker;

  localparam int W    = 5;
  localparam int MOD  = 32;
  localparam int LOCK = 2;
  localparam int LOSS = 3;
  localparam int SMAX = 255;

  logic         clk0;
  logic         reset;
  logic         en;
  logic [W-1:0] count_in;
  logic         locked;
  logic         err_pulse;
  logic         wrap_pulse;
  logic [7:0]   err_count;
  logic [7:0]   wrap_count;
  logic [W-1:0] last_bad;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_seen, m_locked, m_errp, m_wrapp;
  int m_exp, m_run, m_miss, m_err, m_wrap, m_last_bad;

  up5bit_count_checker dut (
    .clk0       (clk0),
    .reset      (reset),
    .en         (en),
    .count_in   (count_in),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .last_bad   (last_bad)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic e, input logic [W-1:0] v);
    en       = e;
    count_in = v;
    @(negedge clk0);
  endtask

  // Reference model: advanced once per sampled edge, then compared after it.
  always begin
    @(posedge clk0 or posedge reset);
    m_errp  = 0;
    m_wrapp = 0;
    if (reset) begin
      m_seen = 0; m_locked = 0; m_exp = 0; m_run = 0; m_miss = 0;
      m_err = 0; m_wrap = 0; m_last_bad = 0;
    end else if (en) begin
      int v;
      v = int'(count_in);
      if (!m_seen) begin
        m_seen = 1;
        m_exp  = (v + 1) % MOD;
        m_run  = 0;
      end else if (!m_locked) begin
        m_run = (v == m_exp) ? m_run + 1 : 0;
        m_exp = (v + 1) % MOD;
        if (m_run == LOCK) begin
          m_locked = 1;
          m_miss   = 0;
        end
      end else if (v == m_exp) begin
        m_miss = 0;
        m_exp  = (m_exp + 1) % MOD;
        if (v == 0) begin
          m_wrapp = 1;
          if (m_wrap < SMAX) m_wrap++;
        end
      end else begin
        m_errp     = 1;
        m_last_bad = v;
        if (m_err < SMAX) m_err++;
        m_miss++;
        m_exp = (m_exp + 1) % MOD;
        if (m_miss == LOSS) begin
          m_locked = 0;
          m_run    = 0;
          m_exp    = (v + 1) % MOD;
        end
      end
    end
    #1;
    check_output("locked",     int'(locked),     int'(m_locked));
    check_output("err_pulse",  int'(err_pulse),  int'(m_errp));
    check_output("wrap_pulse", int'(wrap_pulse), int'(m_wrapp));
    check_output("err_count",  int'(err_count),  m_err);
    check_output("wrap_count", int'(wrap_count), m_wrap);
    check_output("last_bad",   int'(last_bad),   m_last_bad);
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by random traffic and a saturation run.
  initial begin
    int v;
    int r;
    reset    = 1'b1;
    en       = 1'b0;
    count_in = '0;
    repeat (10) @(negedge clk0);
    reset = 1'b0;

    $display("[TB] clean sequence");
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b1, W'(i));
      if (i == 1) check_output("lit_unlocked_after_1", int'(locked), 0);
      if (i == 2) check_output("lit_locked_after_2", int'(locked), 1);
    end
    apply_stimulus(1'b1, 5'd0);
    check_output("lit_wrap_pulse", int'(wrap_pulse), 1);
    check_output("lit_wrap_count_1", int'(wrap_count), 1);
    check_output("lit_clean_err", int'(err_count), 0);

    $display("[TB] single glitch");
    for (int k = 1; k <= 6; k++) apply_stimulus(1'b1, W'(k));
    apply_stimulus(1'b1, 5'd9);
    check_output("lit_glitch_pulse", int'(err_pulse), 1);
    check_output("lit_glitch_last_bad", int'(last_bad), 9);
    apply_stimulus(1'b1, 5'd8);
    apply_stimulus(1'b1, 5'd9);
    apply_stimulus(1'b1, 5'd10);
    check_output("lit_glitch_err_count", int'(err_count), 1);
    check_output("lit_glitch_locked", int'(locked), 1);

    $display("[TB] stuck input");
    apply_stimulus(1'b1, 5'd11);
    apply_stimulus(1'b1, 5'd12);
    apply_stimulus(1'b1, 5'd12);
    check_output("lit_stuck1_locked", int'(locked), 1);
    apply_stimulus(1'b1, 5'd12);
    check_output("lit_stuck2_locked", int'(locked), 1);
    apply_stimulus(1'b1, 5'd12);
    check_output("lit_stuck3_locked", int'(locked), 0);
    check_output("lit_stuck3_pulse", int'(err_pulse), 1);
    check_output("lit_stuck_err_count", int'(err_count), 4);
    apply_stimulus(1'b1, 5'd13);
    check_output("lit_relock_not_yet", int'(locked), 0);
    apply_stimulus(1'b1, 5'd14);
    check_output("lit_relocked", int'(locked), 1);

    $display("[TB] enable gating");
    for (int k = 15; k < 32; k++) apply_stimulus(1'b1, W'(k));
    for (int k = 0; k < 7; k++) apply_stimulus(1'b1, W'(k));
    check_output("lit_wrap_count_2", int'(wrap_count), 2);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b0, W'($urandom_range(0, 31)));
    apply_stimulus(1'b1, 5'd7);
    check_output("lit_gate_err_count", int'(err_count), 4);
    check_output("lit_gate_pulse", int'(err_pulse), 0);
    check_output("lit_gate_locked", int'(locked), 1);

    $display("[TB] mid-run reset");
    #2;
    reset = 1'b1;
    #1;
    check_output("lit_rst_locked", int'(locked), 0);
    check_output("lit_rst_err_count", int'(err_count), 0);
    check_output("lit_rst_wrap_count", int'(wrap_count), 0);
    check_output("lit_rst_last_bad", int'(last_bad), 0);
    @(negedge clk0);
    reset = 1'b0;
    apply_stimulus(1'b1, 5'd20);
    apply_stimulus(1'b1, 5'd21);
    check_output("lit_rst_relock_pending", int'(locked), 0);
    apply_stimulus(1'b1, 5'd22);
    check_output("lit_rst_relock", int'(locked), 1);

    $display("[TB] random traffic");
    v = 22;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        apply_stimulus(1'b0, W'($urandom_range(0, 31)));
      end else if (r < 85) begin
        v = (v + 1) % MOD;
        apply_stimulus(1'b1, W'(v));
      end else if (r < 93) begin
        apply_stimulus(1'b1, W'(v));
      end else begin
        v = int'($urandom_range(0, 31));
        apply_stimulus(1'b1, W'(v));
      end
    end

    $display("[TB] saturation");
    @(negedge clk0);
    reset = 1'b1;
    @(negedge clk0);
    reset = 1'b0;
    v = 0;
    apply_stimulus(1'b1, W'(v));
    for (int i = 0; i < 100; i++) begin
      v = (v + 1) % MOD;
      apply_stimulus(1'b1, W'(v));
      v = (v + 1) % MOD;
      apply_stimulus(1'b1, W'(v));
      repeat (3) apply_stimulus(1'b1, W'(v));
    end
    check_output("lit_sat_err_count", int'(err_count), 255);
    check_output("lit_sat_unlocked", int'(locked), 0);

    apply_stimulus(1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
